sram_phase_scheduler: RTL

Top-level sequencer that owns the single external SRAM port and grants it to one client per phase.
- Phase order: UART image load, then decoder run, then VGA display.
- Drives client Initialize/Enable/start controls, detects end-of-transfer on the UART path with an inactivity timeout or a capacity-reached check, and muxes the client buses onto the SRAM pins.
- Sits between the UART-to-SRAM writer, the decoder and the VGA reader.

---
 rtl/sram_phase_scheduler_pkg.sv | 35 +++
 rtl/sram_phase_scheduler_sram_client_mux.sv | 50 +++++
 rtl/sram_phase_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sram_phase_scheduler_pkg.sv
// Shared types for the SRAM phase scheduler: sequencer states and
// the 2-bit phase codes that select which client owns the SRAM port.
package sram_phase_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UART_ARM,
      S_UART_WAIT_FIRST,
      S_UART_RX,
      S_DECODE,
      S_DISPLAY
   } sram_sched_state_type;

   localparam logic [1:0] PHASE_IDLE    = 2'd0;
   localparam logic [1:0] PHASE_UART    = 2'd1;
   localparam logic [1:0] PHASE_DECODE  = 2'd2;
   localparam logic [1:0] PHASE_DISPLAY = 2'd3;

   function automatic logic [1:0] state_phase(
      input sram_sched_state_type s
   );
      logic [1:0] p;
      p = PHASE_IDLE;
      case (s)
         S_UART_ARM,
         S_UART_WAIT_FIRST,
         S_UART_RX: p = PHASE_UART;
         S_DECODE:  p = PHASE_DECODE;
         S_DISPLAY: p = PHASE_DISPLAY;
         default:   p = PHASE_IDLE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sram_phase_scheduler_sram_client_mux.sv
// Combinational 3-way SRAM client select; any unowned phase releases
// the port (address 0, data 0, we_n high).
// Ports: i_sel phase code; i_a/b/c_* client buses for phases 1/2/3;
//        o_address, o_write_data, o_we_n to the SRAM pins.
module sram_client_mux
   import sram_phase_scheduler_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic [1:0]        i_sel,
   input  logic [ADDR_W-1:0] i_a_address,
   input  logic [DATA_W-1:0] i_a_write_data,
   input  logic              i_a_we_n,
   input  logic [ADDR_W-1:0] i_b_address,
   input  logic [DATA_W-1:0] i_b_write_data,
   input  logic              i_b_we_n,
   input  logic [ADDR_W-1:0] i_c_address,
   input  logic [DATA_W-1:0] i_c_write_data,
   input  logic              i_c_we_n,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_write_data,
   output logic              o_we_n
);

   always_comb begin
      o_address    = '0;
      o_write_data = '0;
      o_we_n       = 1'b1;
      case (i_sel)
         PHASE_UART: begin
            o_address    = i_a_address;
            o_write_data = i_a_write_data;
            o_we_n       = i_a_we_n;
         end
         PHASE_DECODE: begin
            o_address    = i_b_address;
            o_write_data = i_b_write_data;
            o_we_n       = i_b_we_n;
         end
         PHASE_DISPLAY: begin
            o_address    = i_c_address;
            o_write_data = i_c_write_data;
            o_we_n       = i_c_we_n;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sram_phase_scheduler.sv
// Sequencer owning the external SRAM port: UART load, decode, display.
// Ports: Clock/Resetn/Start; uart_*, dec_*, vga_* client buses and
//        controls; SRAM_* muxed pins; phase; load_words (last load).
module sram_phase_scheduler
   import sram_phase_scheduler_pkg::*;
#(
   parameter int UART_TIMEOUT = 25_000_000,
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [ADDR_W-1:0] uart_address,
   input  logic [DATA_W-1:0] uart_write_data,
   input  logic              uart_we_n,
   output logic              uart_initialize,
   output logic              uart_enable,
   input  logic [ADDR_W-1:0] dec_address,
   input  logic [DATA_W-1:0] dec_write_data,
   input  logic              dec_we_n,
   output logic              dec_start,
   input  logic              dec_done,
   input  logic [ADDR_W-1:0] vga_address,
   output logic              vga_enable,
   output logic [ADDR_W-1:0] SRAM_address,
   output logic [DATA_W-1:0] SRAM_write_data,
   output logic              SRAM_we_n,
   output logic [1:0]        phase,
   output logic [ADDR_W-1:0] load_words
);

   localparam int TW = (UART_TIMEOUT > 1) ? $clog2(UART_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(UART_TIMEOUT - 1);

   sram_sched_state_type r_state, w_state_nxt;
   logic [TW-1:0]     r_timer, w_timer_nxt;
   logic [ADDR_W-1:0] r_words, w_words_nxt, w_words_inc;
   logic r_uart_init, w_uart_init_nxt;
   logic r_uart_en,   w_uart_en_nxt;
   logic r_dec_start, w_dec_start_nxt;
   logic r_vga_en,    w_vga_en_nxt;
   logic w_full, w_timeout;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_words     <= '0;
         r_uart_init <= 1'b0;
         r_uart_en   <= 1'b0;
         r_dec_start <= 1'b0;
         r_vga_en    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_words     <= w_words_nxt;
         r_uart_init <= w_uart_init_nxt;
         r_uart_en   <= w_uart_en_nxt;
         r_dec_start <= w_dec_start_nxt;
         r_vga_en    <= w_vga_en_nxt;
      end
   end

   assign w_words_inc = (&r_words) ? r_words : r_words + 1'b1;
   assign w_full      = &uart_address;
   // A write in the timeout cycle wins: only an idle cycle may expire.
   assign w_timeout   = uart_we_n && (r_timer == TIMER_LAST);

   always_comb begin
      w_state_nxt     = r_state;
      w_timer_nxt     = r_timer;
      w_words_nxt     = r_words;
      w_uart_init_nxt = 1'b0;
      w_uart_en_nxt   = r_uart_en;
      w_dec_start_nxt = 1'b0;
      w_vga_en_nxt    = r_vga_en;
      case (r_state)
         S_IDLE: begin
            w_uart_en_nxt = 1'b0;
            w_vga_en_nxt  = 1'b0;
            if (Start) begin
               w_uart_init_nxt = 1'b1;
               w_words_nxt     = '0;
               w_timer_nxt     = '0;
               w_state_nxt     = S_UART_ARM;
            end
         end
         S_UART_ARM: begin
            w_uart_en_nxt = 1'b1;
            w_state_nxt   = S_UART_WAIT_FIRST;
         end
         // Header bytes produce no writes; the first write is counted.
         S_UART_WAIT_FIRST: begin
            if (!uart_we_n) begin
               w_words_nxt = w_words_inc;
               w_timer_nxt = '0;
               w_state_nxt = S_UART_RX;
            end
         end
         S_UART_RX: begin
            if (!uart_we_n) begin
               w_words_nxt = w_words_inc;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
            if (w_full || w_timeout) begin
               w_uart_en_nxt   = 1'b0;
               w_dec_start_nxt = 1'b1;
               w_state_nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_done) begin
               w_vga_en_nxt = 1'b1;
               w_state_nxt  = S_DISPLAY;
            end
         end
         S_DISPLAY: begin
            if (Start) begin
               w_vga_en_nxt    = 1'b0;
               w_uart_init_nxt = 1'b1;
               w_words_nxt     = '0;
               w_timer_nxt     = '0;
               w_state_nxt     = S_UART_ARM;
            end
         end
         default: begin
            w_uart_en_nxt = 1'b0;
            w_vga_en_nxt  = 1'b0;
            w_state_nxt   = S_IDLE;
         end
      endcase
   end

   assign phase           = state_phase(r_state);
   assign uart_initialize = r_uart_init;
   assign uart_enable     = r_uart_en;
   assign dec_start       = r_dec_start;
   assign vga_enable      = r_vga_en;
   assign load_words      = r_words;

   // Selected by the registered phase, so a client's we_n can only
   // reach the pins while its own phase is active.
   sram_client_mux #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_mux (
      .i_sel          (phase),
      .i_a_address    (uart_address),
      .i_a_write_data (uart_write_data),
      .i_a_we_n       (uart_we_n),
      .i_b_address    (dec_address),
      .i_b_write_data (dec_write_data),
      .i_b_we_n       (dec_we_n),
      .i_c_address    (vga_address),
      .i_c_write_data ('0),
      .i_c_we_n       (1'b1),
      .o_address      (SRAM_address),
      .o_write_data   (SRAM_write_data),
      .o_we_n         (SRAM_we_n)
   );

endmodule
